// File: rtl/cpu_pkg.sv
// Shared CPU write-back types: register address / data widths and the load-queue entry.
// No logic, no latency.
// No backpressure; types only.
package cpu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  // One pending register-file write: destination and value.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  // Which source drives the register-file write port this cycle.
  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_ALU  = 2'd1,
    SEL_HEAD = 2'd2,
    SEL_MEM  = 2'd3
  } wb_sel_e;

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Bundle of ALU / load / register-file / hazard-check signals around the write arbiter.
// No logic, no latency.
// alu_stall and mem_ready carry the backpressure back to the producers.
interface reg_write_arbiter_if;
  import cpu_pkg::*;

  logic                  alu_valid;
  logic [REG_ADDR_W-1:0] alu_rd;
  logic [XLEN-1:0]       alu_data;
  logic                  alu_stall;

  logic                  mem_valid;
  logic                  mem_ready;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic [XLEN-1:0]       mem_data;

  logic                  RegWrite;
  logic [REG_ADDR_W-1:0] WriteAddr;
  logic [XLEN-1:0]       WriteData;

  logic [REG_ADDR_W-1:0] rs1Addr;
  logic [REG_ADDR_W-1:0] rs2Addr;
  logic                  rs1Pending;
  logic                  rs2Pending;

  // Producer / register-file side.
  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, rs1Addr, rs2Addr,
    input  alu_stall, mem_ready, RegWrite, WriteAddr, WriteData, rs1Pending, rs2Pending
  );

  // Arbiter side.
  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, rs1Addr, rs2Addr,
    output alu_stall, mem_ready, RegWrite, WriteAddr, WriteData, rs1Pending, rs2Pending
  );

endinterface

// File: rtl/wb_fifo.sv
// Load-result queue: circular buffer of DEPTH write-back entries with per-entry rd visibility.
// Head is visible combinationally; push/pop take effect on the next clock edge.
// Caller must not push when full or pop when empty; simultaneous push+pop keeps the count.
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 i_push,
  input  wb_entry_t                            i_push_entry,
  input  logic                                 i_pop,
  output logic                                 o_full,
  output logic                                 o_empty,
  output wb_entry_t                            o_head,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]     o_entry_rd,
  output logic [DEPTH-1:0]                     o_entry_vld
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Storage array; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_push_entry;
    end
  end

  // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy 0..DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      unique case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];

  // A slot is live when its distance from the read pointer is below the occupancy.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_vis
    logic [PTR_W-1:0] w_off;
    assign w_off           = PTR_W'(gi) - r_rd_ptr;
    assign o_entry_vld[gi] = (CNT_W'(w_off) < r_count);
    assign o_entry_rd[gi]  = r_mem[gi].rd;
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Register-file write-port arbiter: ALU first, then queued loads, then a direct load bypass.
// Write port is registered: a source selected in cycle n is written in cycle n+1.
// alu_stall=full, mem_ready=!full; a same-cycle dequeue never frees room for an enqueue.
// Optional hazard lookup (rs1Pending/rs2Pending) enabled by macro REG_WRITE_ARBITER_PENDING_EN.
module reg_write_arbiter
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  reg_write_arbiter_if.slave   bus
);

  logic                             w_full;
  logic                             w_empty;
  wb_entry_t                        w_head;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] w_entry_rd;
  logic [DEPTH-1:0]                 w_entry_vld;

  wb_sel_e   w_sel;
  logic      w_push;
  logic      w_pop;
  wb_entry_t w_wr_entry;
  logic      w_wr_en;

  logic                  r_reg_write;
  logic [REG_ADDR_W-1:0] r_wr_addr;
  logic [XLEN-1:0]       r_wr_data;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .i_push       (w_push),
    .i_push_entry ({bus.mem_rd, bus.mem_data}),
    .i_pop        (w_pop),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_head       (w_head),
    .o_entry_rd   (w_entry_rd),
    .o_entry_vld  (w_entry_vld)
  );

  assign bus.alu_stall = w_full;
  assign bus.mem_ready = !w_full;

  // Source selection and queue control; loads for x0 are accepted but never queued.
  always_comb begin
    w_sel  = SEL_NONE;
    w_push = 1'b0;
    w_pop  = 1'b0;
    if (w_full) begin
      w_sel = SEL_HEAD;
      w_pop = 1'b1;
    end else if (bus.alu_valid) begin
      w_sel  = SEL_ALU;
      w_push = bus.mem_valid && (bus.mem_rd != '0);
    end else if (!w_empty) begin
      w_sel  = SEL_HEAD;
      w_pop  = 1'b1;
      w_push = bus.mem_valid && (bus.mem_rd != '0);
    end else if (bus.mem_valid) begin
      w_sel = SEL_MEM;
    end
  end

  // Write-port mux; a selected x0 write is dropped here.
  always_comb begin
    w_wr_entry = '0;
    case (w_sel)
      SEL_ALU:  w_wr_entry = {bus.alu_rd, bus.alu_data};
      SEL_HEAD: w_wr_entry = w_head;
      SEL_MEM:  w_wr_entry = {bus.mem_rd, bus.mem_data};
      default:  w_wr_entry = '0;
    endcase
    w_wr_en = (w_sel != SEL_NONE) && (w_wr_entry.rd != '0);
  end

  // Registered write port; address/data hold when nothing is written.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_reg_write <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
    end else begin
      r_reg_write <= w_wr_en;
      if (w_wr_en) begin
        r_wr_addr <= w_wr_entry.rd;
        r_wr_data <= w_wr_entry.data;
      end
    end
  end

  assign bus.RegWrite  = r_reg_write;
  assign bus.WriteAddr = r_wr_addr;
  assign bus.WriteData = r_wr_data;

`ifdef REG_WRITE_ARBITER_PENDING_EN
  logic w_rs1_pend;
  logic w_rs2_pend;

  // A source is pending while a live queue slot or the in-flight write targets it; x0 never is.
  always_comb begin
    w_rs1_pend = r_reg_write && (r_wr_addr == bus.rs1Addr);
    w_rs2_pend = r_reg_write && (r_wr_addr == bus.rs2Addr);
    for (int i = 0; i < DEPTH; i++) begin
      if (w_entry_vld[i] && (w_entry_rd[i] == bus.rs1Addr)) w_rs1_pend = 1'b1;
      if (w_entry_vld[i] && (w_entry_rd[i] == bus.rs2Addr)) w_rs2_pend = 1'b1;
    end
    if (bus.rs1Addr == '0) w_rs1_pend = 1'b0;
    if (bus.rs2Addr == '0) w_rs2_pend = 1'b0;
  end

  assign bus.rs1Pending = w_rs1_pend;
  assign bus.rs2Pending = w_rs2_pend;
`else
  // Hazard lookup compiled out: flags tied low, visibility signals only folded together.
  logic w_unused_pend;
  assign w_unused_pend  = ^{w_entry_vld, w_entry_rd, bus.rs1Addr, bus.rs2Addr};
  assign bus.rs1Pending = 1'b0;
  assign bus.rs2Pending = 1'b0;
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter against a queue-based reference model.
// One cycle per step; outputs sampled 1 time unit after inputs settle and after each edge.
// Directed scenarios first, then randomized traffic with producers holding while stalled.
module tb_reg_write_arbiter;
  import cpu_pkg::*;

  localparam int DEPTH = 4;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  reg_write_arbiter_if bus();

  reg_write_arbiter #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pending loads in arrival order plus the write-port state.
  wb_entry_t   m_q[$];
  logic        exp_we;
  logic [4:0]  exp_addr;
  logic [31:0] exp_data;

  function automatic logic m_pend(input logic [4:0] rs);
`ifdef REG_WRITE_ARBITER_PENDING_EN
    if (rs == 5'd0) return 1'b0;
    if (exp_we && exp_addr == rs) return 1'b1;
    foreach (m_q[i]) if (m_q[i].rd == rs) return 1'b1;
    return 1'b0;
`else
    return (rs == 5'd31) && (rs == 5'd0);
`endif
  endfunction

  task automatic model_clear();
    m_q.delete();
    exp_we   = 1'b0;
    exp_addr = '0;
    exp_data = '0;
  endtask

  task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                      input logic mv, input logic [4:0] mrd, input logic [31:0] mdat,
                      input logic [4:0] r1, input logic [4:0] r2);
    wb_entry_t sel;
    bit        have;
    bit        full;
    logic      e1, e2;
    bus.alu_valid = av;  bus.alu_rd = ard;  bus.alu_data = adat;
    bus.mem_valid = mv;  bus.mem_rd = mrd;  bus.mem_data = mdat;
    bus.rs1Addr   = r1;  bus.rs2Addr = r2;
    #1;
    full = (m_q.size() == DEPTH);
    e1   = m_pend(r1);
    e2   = m_pend(r2);
    n_checks++;
    if (bus.alu_stall !== full) begin
      n_fail++; $display("FAIL alu_stall: got %b expected %b", bus.alu_stall, full);
    end
    n_checks++;
    if (bus.mem_ready !== !full) begin
      n_fail++; $display("FAIL mem_ready: got %b expected %b", bus.mem_ready, !full);
    end
    n_checks++;
    if (bus.rs1Pending !== e1) begin
      n_fail++; $display("FAIL rs1Pending rs=%0d: got %b expected %b", r1, bus.rs1Pending, e1);
    end
    n_checks++;
    if (bus.rs2Pending !== e2) begin
      n_fail++; $display("FAIL rs2Pending rs=%0d: got %b expected %b", r2, bus.rs2Pending, e2);
    end
    // Next write: full queue drains, else ALU, else oldest load, else a fresh load.
    have = 1'b0;
    sel  = '0;
    if (full) begin
      sel = m_q.pop_front(); have = 1'b1;
    end else begin
      if (av) begin
        sel = {ard, adat}; have = 1'b1;
      end else if (m_q.size() > 0) begin
        sel = m_q.pop_front(); have = 1'b1;
      end else if (mv) begin
        sel = {mrd, mdat}; have = 1'b1;
        mv  = 1'b0;
      end
      if (mv && mrd != 5'd0 && (av || have)) m_q.push_back({mrd, mdat});
    end
    exp_we = have && (sel.rd != 5'd0);
    if (exp_we) begin
      exp_addr = sel.rd;
      exp_data = sel.data;
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.RegWrite !== exp_we) begin
      n_fail++; $display("FAIL RegWrite: got %b expected %b", bus.RegWrite, exp_we);
    end
    n_checks++;
    if (bus.WriteAddr !== exp_addr) begin
      n_fail++; $display("FAIL WriteAddr: got %0d expected %0d", bus.WriteAddr, exp_addr);
    end
    n_checks++;
    if (bus.WriteData !== exp_data) begin
      n_fail++; $display("FAIL WriteData: got %h expected %h", bus.WriteData, exp_data);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++; $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
    bus.mem_valid = 0; bus.mem_rd = 0; bus.mem_data = 0;
    bus.rs1Addr = 0;   bus.rs2Addr = 0;
    repeat (2) @(posedge clk);
    #1;
    check_val("reset_RegWrite", 32'(bus.RegWrite), 32'd0);
    check_val("reset_WriteAddr", 32'(bus.WriteAddr), 32'd0);
    check_val("reset_WriteData", bus.WriteData, 32'd0);
    reset = 1'b0;
    model_clear();
    #1;
    check_val("post_reset_mem_ready", 32'(bus.mem_ready), 32'd1);
    check_val("post_reset_alu_stall", 32'(bus.alu_stall), 32'd0);
  endtask

  task automatic test_alu_write();
    step(1, 5, 32'h11, 0, 0, 0, 0, 0);
    check_val("alu_RegWrite", 32'(bus.RegWrite), 32'd1);
    check_val("alu_WriteAddr", 32'(bus.WriteAddr), 32'd5);
    check_val("alu_WriteData", bus.WriteData, 32'h11);
    idle(1);
  endtask

  task automatic test_alu_mem_same();
    step(1, 3, 32'hA3, 1, 7, 32'hB7, 0, 0);
    check_val("same_first_addr", 32'(bus.WriteAddr), 32'd3);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check_val("same_second_addr", 32'(bus.WriteAddr), 32'd7);
    check_val("same_second_data", bus.WriteData, 32'hB7);
    idle(1);
  endtask

  task automatic test_fill_fifo();
    for (int i = 0; i < 4; i++) step(1, 5'(1 + i), 32'(i), 1, 5'(10 + i), 32'h100 + 32'(i), 0, 0);
    // Queue now full: ALU held off, head drained, new load refused.
    step(1, 6, 32'h66, 1, 5'd20, 32'h200, 0, 0);
    check_val("full_drain_addr", 32'(bus.WriteAddr), 32'd10);
    for (int i = 0; i < 3; i++) step(1, 6, 32'h66, 0, 0, 0, 0, 0);
    idle(5);
  endtask

  task automatic test_rd_zero();
    step(1, 0, 32'hDEAD, 1, 0, 32'hBEEF, 0, 0);
    check_val("rd0_RegWrite", 32'(bus.RegWrite), 32'd0);
    step(0, 0, 0, 1, 0, 32'hCAFE, 0, 0);
    check_val("rd0_bypass_RegWrite", 32'(bus.RegWrite), 32'd0);
    // Queue still empty: a load goes straight through.
    step(0, 0, 0, 1, 5'd12, 32'h12, 0, 0);
    check_val("rd0_after_addr", 32'(bus.WriteAddr), 32'd12);
    idle(1);
  endtask

  task automatic test_pending();
    step(1, 4, 32'h44, 1, 9, 32'h99, 9, 0);
    step(1, 4, 32'h45, 0, 0, 0, 9, 9);
    step(0, 0, 0, 0, 0, 0, 9, 0);
    step(0, 0, 0, 0, 0, 0, 9, 0);
    step(0, 0, 0, 0, 0, 0, 9, 0);
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 3; i++) step(1, 5'(1 + i), 32'(i), 1, 5'(10 + i), 32'h300 + 32'(i), 0, 0);
    reset = 1'b1;
    bus.alu_valid = 0; bus.mem_valid = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
    check_val("midrst_RegWrite", 32'(bus.RegWrite), 32'd0);
    check_val("midrst_WriteAddr", 32'(bus.WriteAddr), 32'd0);
    check_val("midrst_mem_ready", 32'(bus.mem_ready), 32'd1);
    idle(4);
    // Four more loads must fit exactly, proving the queue restarted empty.
    for (int i = 0; i < 5; i++) step(1, 5'd1, 32'(i), 1, 5'(20 + i), 32'h400 + 32'(i), 0, 0);
    idle(6);
  endtask

  task automatic test_random();
    logic av, mv;
    logic [4:0] ard, mrd;
    logic [31:0] adat, mdat;
    av = 0; mv = 0; ard = 0; mrd = 0; adat = 0; mdat = 0;
    for (int c = 0; c < 400; c++) begin
      if (!(av && m_q.size() == DEPTH)) begin
        av   = ($urandom_range(0, 99) < 45);
        ard  = 5'($urandom_range(0, 7));
        adat = $urandom;
      end
      if (!(mv && m_q.size() == DEPTH)) begin
        mv   = ($urandom_range(0, 99) < 60);
        mrd  = 5'($urandom_range(0, 7));
        mdat = $urandom;
      end
      step(av, ard, adat, mv, mrd, mdat, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    idle(6);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    model_clear();
    test_reset();
    test_alu_write();
    test_alu_mem_same();
    test_fill_fifo();
    test_rd_zero();
    test_pending();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
